dmem_rr_arbiter: RTL
====================

Name: dmem_rr_arbiter

Overview:
- Parametrised N-requester to one-BRAM-port arbiter for data memory. It is the reusable successor to the hard-coded vector-LSU round-robin on port B.
- Adds per-request tag tracking through a configurable BRAM read latency, so read data returns to the requester that issued it, not to whoever holds the grant when data emerges.
- Adds optional per-requester partition address translation with range checking.
- One instance per BRAM port per core. The scalar port uses NUM_REQ=1.

Parameters:
- NUM_REQ, 16, number of requesters (LSUs); must be ≥1.
- ADDR_W, 32, address width (data_memory_address_t).
- DATA_W, 32, data width (data_t); must be a multiple of 8.
- READ_LATENCY, 1, BRAM cycles from mem_en to valid mem_dout; range 1..4.
- OUT_REG, 1, 1 adds a register stage on mem_dout before return.
- PARTITIONED, 1, 1 enables base + idx*PART_SIZE + local translation; 0 passes the address through.
- PART_BASE, THREAD_LOCAL_MEM_BASE_ADDR, base of the partitioned region.
- PART_SIZE, THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS, words per requester partition.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_read_valid  in  NUM_REQ  per-requester read request.
- req_write_valid  in  NUM_REQ  per-requester write request.
- req_read_address  in  NUM_REQ x ADDR_W  read address (local when PARTITIONED).
- req_write_address  in  NUM_REQ x ADDR_W  write address.
- req_write_data  in  NUM_REQ x DATA_W  write data.
- req_read_ready  out  NUM_REQ  read accepted this cycle.
- req_write_ready  out  NUM_REQ  write accepted this cycle.
- req_read_data  out  NUM_REQ x DATA_W  last returned read data, held per requester.
- req_read_data_valid  out  NUM_REQ  one-cycle pulse when req_read_data updates.
- err_range  out  NUM_REQ  sticky flag: out-of-partition access attempted.
- mem_en  out  1  BRAM enable.
- mem_we  out  DATA_W/8  byte write enables (all-or-none).
- mem_addr  out  ADDR_W  physical address.
- mem_din  out  DATA_W  write data.
- mem_dout  in  DATA_W  BRAM read data.

Behaviour:
- Reset:
  - Reset is asynchronous. While it is asserted: grant_ptr=0, tag pipeline flushed, all req_read_data=0, req_read_data_valid=0, err_range=0.
  - The combinational outputs derive from the reset state, so with no requests mem_en=0 and mem_we=0.
  - In-flight reads at reset are dropped and produce no pulse.
- Arbitration:
  - Combinational round-robin scan starting at grant_ptr. The first index with read_valid or write_valid wins.
  - On a grant, grant_ptr <= winner+1, wrapping modulo NUM_REQ. With no grant, grant_ptr holds.
  - At most one access per cycle.
- Handshake:
  - Ready is combinational: ready = grant and (selected op). An access is accepted when valid and ready are both high in the same cycle.
  - A requester asserting both read and write gets the write served first. Its read_ready stays 0 that cycle, and the read is retried on its next grant.
  - Requesters must hold valid, address and data until ready.
- Address translation:
  - PARTITIONED=1: mem_addr = PART_BASE + idx*PART_SIZE + local, computed at ADDR_W width with wrap truncation.
  - If local ≥ PART_SIZE: the access is accepted (ready=1), but mem_en=0 and mem_we=0, and err_range[idx] sets. An out-of-range read still returns a response pulse with data 0.
  - PARTITIONED=0: mem_addr = local, and no range check is made.
- Memory drive: mem_en=1 on a valid in-range grant. mem_we is all-ones for a write, else 0. mem_din = the granted requester's write data.
- Read return:
  - Each accepted read pushes {valid, idx, oor} into a shift pipeline of depth READ_LATENCY+OUT_REG. Writes push valid=0.
  - At the pipeline tail, req_read_data[idx] <= (oor ? 0 : returned data) and req_read_data_valid[idx] pulses for 1 cycle.
  - Total latency from accept to pulse: READ_LATENCY+OUT_REG cycles (default 2).
  - Fully pipelined: back-to-back reads from different or the same requesters each return in order.
- Simultaneous events: a new grant and a return in the same cycle are independent. A requester may be re-granted while its earlier read is in flight.
- Degenerate case NUM_REQ=1: the index width is forced to 1 and the grant_ptr stays 0.

Decomposition:
- Shared package gpu_defines: data_t, data_memory_address_t, DATA_MEMORY_WE_WIDTH, THREAD_LOCAL_MEM_BASE_ADDR, THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS, and a new localparam-derived rr_idx width helper.
- One sub-module: rr_pick, a combinational round-robin priority picker (request vector, pointer → winner idx, valid). It is reused by the instruction arbiter.

Test Plan:
- Default parameters; requesters 3 and 7 each assert a read at local address 5 in the same cycle:
  - Cycle 0: grant goes to 3 with mem_addr = PART_BASE+3*PART_SIZE+5.
  - Cycle 1: grant goes to 7.
  - req_read_data_valid[3] pulses at cycle 2 and [7] at cycle 3, each with the matching mem_dout.
- Requester 0 writes 0xDEADBEEF to local 2, then reads local 2 → mem_we=0xF on the write; the read returns 0xDEADBEEF two cycles after its accept, and only bit 0 of req_read_data_valid pulses.
- All 16 requesters hold reads continuously → grants are issued 0,1,…,15,0 in strict rotation with no gap, and each sees one pulse per 16 cycles.
- PART_SIZE=64, requester 4 reads local 64 → read_ready=1, mem_en=0, err_range[4]=1 and sticky, and a pulse arrives with data 0.
- READ_LATENCY=3, OUT_REG=0; issue a read, then assert reset asynchronously 1 cycle later (mid-flight) → no pulse, and all outputs are 0 immediately without waiting for a clock edge.
- Requester 5 asserts read and write together → write granted first (write_ready=1, read_ready=0); the read is granted on the next rotation back to 5.

Source files
------------

// File: rtl/dmem_rr_arbiter_pkg.sv
// Shared data-memory types and constants for the DMEM arbiter slice.
// Also hosts the round-robin index-width helper used by all arbiters.
package dmem_rr_arbiter_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] data_memory_address_t;

    localparam int unsigned DATA_MEMORY_WE_WIDTH = $bits(data_t) / 8;

    localparam data_memory_address_t THREAD_LOCAL_MEM_BASE_ADDR = 32'h0000_8000;
    localparam int unsigned THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS = 64;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } dmem_op_e;

    // A single requester still needs a 1-bit index so vectors stay legal.
    function automatic int unsigned rr_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rr_arbiter_if.sv
// Requester-side bus of the DMEM arbiter: per-requester read/write handshakes,
// returned read data and sticky range-error flags.
interface dmem_rr_arbiter_if
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 16,
    parameter int unsigned ADDR_W  = $bits(data_memory_address_t),
    parameter int unsigned DATA_W  = $bits(data_t)
);

    logic [NUM_REQ-1:0]             req_read_valid;
    logic [NUM_REQ-1:0]             req_write_valid;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_read_address;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_write_address;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_write_data;
    logic [NUM_REQ-1:0]             req_read_ready;
    logic [NUM_REQ-1:0]             req_write_ready;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_read_data;
    logic [NUM_REQ-1:0]             req_read_data_valid;
    logic [NUM_REQ-1:0]             err_range;

    modport master (
        output req_read_valid, req_write_valid, req_read_address,
               req_write_address, req_write_data,
        input  req_read_ready, req_write_ready, req_read_data,
               req_read_data_valid, err_range
    );

    modport slave (
        input  req_read_valid, req_write_valid, req_read_address,
               req_write_address, req_write_data,
        output req_read_ready, req_write_ready, req_read_data,
               req_read_data_valid, err_range
    );

endinterface

// File: rtl/dmem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after ptr.
// Shared with the instruction-memory arbiter.
module rr_pick
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = rr_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    int unsigned j;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = 32'(ptr) + i;
            if (j >= N) j = j - N;
            if (!valid && req[j[IDX_W-1:0]]) begin
                valid = 1'b1;
                idx   = j[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// N-requester round-robin arbiter onto one BRAM port, with partition address
// translation and a tag pipeline steering read data back to its issuer.
module dmem_rr_arbiter
    import dmem_rr_arbiter_pkg::*;
#(
    parameter int unsigned       NUM_REQ      = 16,
    parameter int unsigned       ADDR_W       = $bits(data_memory_address_t),
    parameter int unsigned       DATA_W       = $bits(data_t),
    parameter int unsigned       READ_LATENCY = 1,
    parameter int unsigned       OUT_REG      = 1,
    parameter int unsigned       PARTITIONED  = 1,
    parameter logic [ADDR_W-1:0] PART_BASE    = ADDR_W'(THREAD_LOCAL_MEM_BASE_ADDR),
    parameter int unsigned       PART_SIZE    = THREAD_LOCAL_MEM_PARTITION_SIZE_WORDS
) (
    input  logic                clk,
    input  logic                reset,
    dmem_rr_arbiter_if.slave    bus,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_din,
    input  logic [DATA_W-1:0]   mem_dout
);

    localparam int unsigned IDX_W = rr_idx_w(NUM_REQ);
    localparam int unsigned WE_W  = DATA_W / 8;

    logic [IDX_W-1:0]   grant_ptr;
    logic [IDX_W-1:0]   win;
    logic               grant_v;
    logic [NUM_REQ-1:0] any_req;
    dmem_op_e           op;
    logic [ADDR_W-1:0]  local_addr;
    logic [ADDR_W-1:0]  phys_addr;
    logic               oor;
    logic [NUM_REQ-1:0] err_q;

    assign any_req = bus.req_read_valid | bus.req_write_valid;

    rr_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req   (any_req),
        .ptr   (grant_ptr),
        .idx   (win),
        .valid (grant_v)
    );

    // Write wins over a simultaneous read from the same requester.
    always_comb begin
        op = OP_NONE;
        if (grant_v) op = bus.req_write_valid[win] ? OP_WRITE : OP_READ;
    end

    assign local_addr = (op == OP_WRITE) ? bus.req_write_address[win]
                                         : bus.req_read_address[win];

    if (PARTITIONED != 0) begin : g_part
        assign phys_addr = PART_BASE + ADDR_W'(win) * ADDR_W'(PART_SIZE) + local_addr;
        assign oor       = (local_addr >= ADDR_W'(PART_SIZE));
    end else begin : g_flat
        assign phys_addr = local_addr;
        assign oor       = 1'b0;
    end

    assign mem_en   = grant_v && !oor;
    assign mem_we   = {WE_W{(op == OP_WRITE) && !oor}};
    assign mem_addr = phys_addr;
    assign mem_din  = bus.req_write_data[win];

    always_comb begin
        bus.req_read_ready  = '0;
        bus.req_write_ready = '0;
        if (op == OP_READ)  bus.req_read_ready[win]  = 1'b1;
        if (op == OP_WRITE) bus.req_write_ready[win] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_ptr <= '0;
            err_q     <= '0;
        end else if (grant_v) begin
            grant_ptr <= (32'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
            if (oor) err_q[win] <= 1'b1;
        end
    end

    assign bus.err_range = err_q;

    // Tag shift register: tail stage lines up with valid mem_dout.
    logic [READ_LATENCY-1:0]            tag_v;
    logic [READ_LATENCY-1:0]            tag_oor;
    logic [READ_LATENCY-1:0][IDX_W-1:0] tag_idx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v   <= '0;
            tag_oor <= '0;
            tag_idx <= '0;
        end else begin
            tag_v   <= READ_LATENCY'({tag_v, op == OP_READ});
            tag_oor <= READ_LATENCY'({tag_oor, oor});
            tag_idx <= (READ_LATENCY*IDX_W)'({tag_idx, win});
        end
    end

    logic                           ret_v;
    logic [IDX_W-1:0]               ret_idx;
    logic [DATA_W-1:0]              ret_data;
    logic [NUM_REQ-1:0]             pulse;
    logic [NUM_REQ-1:0][DATA_W-1:0] data_q;

    assign ret_v    = tag_v[READ_LATENCY-1];
    assign ret_idx  = tag_idx[READ_LATENCY-1];
    assign ret_data = tag_oor[READ_LATENCY-1] ? '0 : mem_dout;

    always_comb begin
        pulse = '0;
        if (ret_v) pulse[ret_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      data_q <= '0;
        else if (ret_v) data_q[ret_idx] <= ret_data;
    end

    // Without the output register the held data is bypassed in the return cycle.
    if (OUT_REG != 0) begin : g_out_reg
        logic [NUM_REQ-1:0] pulse_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) pulse_q <= '0;
            else       pulse_q <= pulse;
        end
        assign bus.req_read_data       = data_q;
        assign bus.req_read_data_valid = pulse_q;
    end else begin : g_out_comb
        always_comb begin
            bus.req_read_data = data_q;
            if (ret_v) bus.req_read_data[ret_idx] = ret_data;
        end
        assign bus.req_read_data_valid = pulse;
    end

endmodule
